// File: rtl/bcd_pkg.sv
// bcd_pkg: shared state type, constants and digit-count helper for bin_to_bcd_seq
package bcd_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam logic [3:0] ADD3_THRESHOLD = 4'd5;
  function automatic int min_digits(input int width);
    logic [63:0] m;
    int d;
    m = (64'd1 << width) - 64'd1;
    d = 1;
    for (int i = 0; i < 12; i++)
      if (m >= 64'd10) begin
        m = m / 64'd10;
        d++;
      end
    return d;
  endfunction
endpackage

// File: rtl/bcd_add3.sv
// bcd_add3: double-dabble digit correction, adds 3 to a scratch digit of 5 or more
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);
  assign dout = din >= ADD3_THRESHOLD ? din + 4'd3 : din;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: one-bit-per-clock shift-and-add-3 converter; define BCD_BLANK_EN for leading-zero blanking
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  ready,
  output logic                  valid,
  output logic [4*DIGITS-1:0]   bcd
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] sr, sr_n;
  logic [4*DIGITS-1:0] scratch, scratch_n, adj, result;
  if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
    $error("bin_to_bcd_seq: WIDTH must be in 4..32");
  end
  if (DIGITS < min_digits(WIDTH)) begin : g_bad_digits
    $error("bin_to_bcd_seq: DIGITS too small for WIDTH");
  end
  for (genvar i = 0; i < DIGITS; i++) begin : g_add3
    bcd_add3 u_add3 (.din(scratch[4*i+:4]), .dout(adj[4*i+:4]));
  end
  always_comb {scratch_n, sr_n} = {adj, sr} << 1;
`ifdef BCD_BLANK_EN
  logic lead;
  always_comb begin
    result = scratch;
    lead = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (lead && scratch[4*i+:4] == 4'd0) result[4*i+:4] = BLANK_CODE;
      else lead = 1'b0;
    end
  end
`else
  assign result = scratch;
`endif
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    state_n = state == IDLE  ? (start ? SHIFT : IDLE) :
              state == SHIFT ? (cnt == CW'(1) ? DONE : SHIFT) : IDLE;
  end
  assign ready = state == IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      sr      <= '0;
      scratch <= '0;
      valid   <= 1'b0;
      bcd     <= '0;
    end else begin
      valid <= state == DONE;
      if (state == IDLE && start) begin
        sr      <= bin;
        scratch <= '0;
        cnt     <= CW'(WIDTH);
      end
      if (state == SHIFT) begin
        sr      <= sr_n;
        scratch <= scratch_n;
        cnt     <= cnt - CW'(1);
      end
      if (state == DONE) bcd <= result;
    end
  end
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: directed self-checking bench for bin_to_bcd_seq (16-bit and 8-bit instances)
module tb_bin_to_bcd_seq;
  logic clk = 1'b0;
  logic rst, start, start8;
  logic [15:0] bin;
  logic [7:0] bin8;
  logic ready, valid, ready8, valid8;
  logic [19:0] bcd;
  logic [11:0] bcd8;
  int tests = 0;
  int fails = 0;
`ifdef BCD_BLANK_EN
  localparam logic [19:0] X0 = 20'hFFFF0, X9 = 20'hFFFF9, X10 = 20'hFFF10, X100 = 20'hFF100;
  localparam logic [19:0] X999 = 20'hFF999, X1234 = 20'hF1234, X4321 = 20'hF4321;
`else
  localparam logic [19:0] X0 = 20'h00000, X9 = 20'h00009, X10 = 20'h00010, X100 = 20'h00100;
  localparam logic [19:0] X999 = 20'h00999, X1234 = 20'h01234, X4321 = 20'h04321;
`endif
  bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) u_dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .ready(ready), .valid(valid), .bcd(bcd)
  );
  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .bin(bin8),
    .ready(ready8), .valid(valid8), .bcd(bcd8)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic run16(input logic [15:0] b, output logic [19:0] got, output int lat);
    bin = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = -1;
    got = 'x;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (valid) begin
        lat = n;
        got = bcd;
        break;
      end
    end
  endtask
  function automatic logic [11:0] ref8(input int v);
    logic [3:0] d2, d1, d0;
    d2 = 4'(v / 100);
    d1 = 4'((v / 10) % 10);
    d0 = 4'(v % 10);
`ifdef BCD_BLANK_EN
    if (d2 == 4'd0) begin
      d2 = 4'hF;
      if (d1 == 4'd0) d1 = 4'hF;
    end
`endif
    return {d2, d1, d0};
  endfunction
  task automatic test_reset;
    rst = 1'b1;
    start = 1'b1;
    bin = 16'd5;
    tick();
    tick();
    tests++;
    if (ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b want=1", ready); end
    tests++;
    if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b want=0", valid); end
    tests++;
    if (bcd !== 20'h0) begin fails++; $display("FAIL reset_bcd got=%h want=00000", bcd); end
    tests++;
    if (ready8 !== 1'b1 || valid8 !== 1'b0 || bcd8 !== 12'h0)
      begin fails++; $display("FAIL reset_dut8 got=%b/%b/%h want=1/0/000", ready8, valid8, bcd8); end
    rst = 1'b0;
    start = 1'b0;
    tick();
    tests++;
    if (ready !== 1'b1) begin fails++; $display("FAIL reset_idle got=%b want=1", ready); end
  endtask
  task automatic test_values;
    logic [15:0] vb [6] = '{16'd0, 16'd65535, 16'd1234, 16'd9, 16'd100, 16'd10000};
    logic [19:0] vx [6] = '{X0, 20'h65535, X1234, X9, X100, 20'h10000};
    logic [19:0] got;
    int lat;
    for (int k = 0; k < 6; k++) begin
      run16(vb[k], got, lat);
      tests++;
      if (lat != 17) begin fails++; $display("FAIL latency_%0d got=%0d want=17", vb[k], lat); end
      tests++;
      if (got !== vx[k]) begin fails++; $display("FAIL convert_%0d got=%h want=%h", vb[k], got, vx[k]); end
    end
  endtask
  task automatic test_bin_change;
    int cnt_v = 0;
    int lat = -1;
    logic [19:0] got = 'x;
    bin = 16'd999;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (n == 4) begin bin = 16'd1; start = 1'b1; end
      if (n == 7) start = 1'b0;
      tick();
      if (valid) begin
        cnt_v++;
        if (lat < 0) begin lat = n; got = bcd; end
      end
    end
    tests++;
    if (cnt_v != 1) begin fails++; $display("FAIL change_valid_count got=%0d want=1", cnt_v); end
    tests++;
    if (lat != 17) begin fails++; $display("FAIL change_latency got=%0d want=17", lat); end
    tests++;
    if (got !== X999) begin fails++; $display("FAIL change_bcd got=%h want=%h", got, X999); end
  endtask
  task automatic test_abort;
    int cnt_v = 0;
    logic [19:0] got;
    int lat;
    bin = 16'd4321;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if (ready !== 1'b1) begin fails++; $display("FAIL abort_ready got=%b want=1", ready); end
    tests++;
    if (bcd !== 20'h0 || valid !== 1'b0) begin fails++; $display("FAIL abort_clear got=%h/%b want=00000/0", bcd, valid); end
    for (int n = 0; n < 25; n++) begin
      tick();
      if (valid) cnt_v++;
    end
    tests++;
    if (cnt_v != 0) begin fails++; $display("FAIL abort_no_valid got=%0d want=0", cnt_v); end
    run16(16'd4321, got, lat);
    tests++;
    if (lat != 17 || got !== X4321) begin fails++; $display("FAIL abort_reconvert got=%h@%0d want=%h@17", got, lat, X4321); end
  endtask
  task automatic test_back_to_back;
    int pulses = 0;
    int prev = 0;
    bin = 16'd10;
    start = 1'b1;
    for (int n = 1; n <= 80; n++) begin
      tick();
      if (valid) begin
        pulses++;
        tests++;
        if (n - prev != 18) begin fails++; $display("FAIL b2b_spacing got=%0d want=18", n - prev); end
        tests++;
        if (bcd !== X10) begin fails++; $display("FAIL b2b_bcd got=%h want=%h", bcd, X10); end
        prev = n;
      end
    end
    tests++;
    if (pulses != 4) begin fails++; $display("FAIL b2b_pulses got=%0d want=4", pulses); end
    start = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask
  task automatic test_sweep8;
    logic [11:0] got, want;
    int lat;
    logic legal;
    for (int b = 0; b < 256; b++) begin
      bin8 = 8'(b);
      start8 = 1'b1;
      tick();
      start8 = 1'b0;
      lat = -1;
      got = 'x;
      for (int n = 1; n <= 20; n++) begin
        tick();
        if (valid8) begin lat = n; got = bcd8; break; end
      end
      want = ref8(b);
      legal = 1'b1;
      for (int d = 0; d < 3; d++)
`ifdef BCD_BLANK_EN
        if (got[4*d+:4] > 4'd9 && !(d > 0 && got[4*d+:4] == 4'hF)) legal = 1'b0;
`else
        if (got[4*d+:4] > 4'd9) legal = 1'b0;
`endif
      tests++;
      if (lat != 9 || got !== want || !legal)
        begin fails++; $display("FAIL sweep8_%0d got=%h@%0d want=%h@9", b, got, lat, want); end
    end
  endtask
  initial begin
    rst = 1'b1;
    start = 1'b0;
    start8 = 1'b0;
    bin = '0;
    bin8 = '0;
    test_reset();
    test_values();
    test_bin_change();
    test_abort();
    test_back_to_back();
    test_sweep8();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
